// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Operation codes match the instruction's funct3 field.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int MD_ITERATIONS = 32;

  function automatic logic is_div(input md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_signed_a(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/e_muldiv_core.sv
// Iteration datapath: shift-add multiplier and restoring divider on unsigned
// magnitudes. Both advance on every step; the parent picks the result.
module e_muldiv_core
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic [DATA_WIDTH-1:0]   a_mag,
  input  logic [DATA_WIDTH-1:0]   b_mag,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]   remainder
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] prod_q;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   dvsr_q;
  logic [W-1:0]   quot_q;
  logic [W-1:0]   rem_q;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_take;

  // Multiplier occupies the low half of prod_q and is consumed LSB first.
  assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift = {rem_q, quot_q[W-1]};
  assign div_diff  = div_shift - {1'b0, dvsr_q};
  // A clear top bit means the shifted remainder was at least the divisor.
  assign div_take  = ~div_diff[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (load) begin
      prod_q  <= {{W{1'b0}}, b_mag};
      mcand_q <= a_mag;
      dvsr_q  <= b_mag;
      quot_q  <= a_mag;
      rem_q   <= '0;
    end else if (step) begin
      prod_q  <= {mul_sum, prod_q[W-1:1]};
      rem_q   <= div_take ? div_diff[W-1:0] : div_shift[W-1:0];
      quot_q  <= {quot_q[W-2:0], div_take};
    end
  end

  assign product   = prod_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/e_muldiv_unit.sv
// Execute-stage RV32M unit: accepts an M instruction, stalls the pipeline for
// 32 iterations, then presents a sign-corrected result for one cycle.
module e_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E_md_start,
  input  logic [2:0]            E_md_op,
  input  logic [DATA_WIDTH-1:0] E_r_out1,
  input  logic [DATA_WIDTH-1:0] E_r_out2,
  input  logic [4:0]            E_rd,
  input  logic                  E_flush,
  output logic                  E_md_stall,
  output logic                  E_md_done,
  output logic [DATA_WIDTH-1:0] E_md_result,
  output logic [4:0]            E_md_rd
);

  localparam int W = DATA_WIDTH;

  md_state_e      state;
  logic [4:0]     count;
  md_op_e         op_q;
  logic [4:0]     rd_q;
  logic           res_neg_q;
  logic           div_zero_q;
  logic [W-1:0]   result_hold;
  logic [4:0]     rd_hold;

  md_op_e         op_in;
  logic           accept;
  logic           last_iter;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  logic [2*W-1:0] product;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   sel_result;

  assign op_in     = md_op_e'(E_md_op);
  assign accept    = (state == IDLE) && E_md_start && !E_flush;
  assign last_iter = (count == 5'(MD_ITERATIONS - 1));

  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  assign a_neg = op_signed_a(op_in) && E_r_out1[W-1];
  assign b_neg = op_signed_b(op_in) && E_r_out2[W-1];
  assign a_mag = a_neg ? -E_r_out1 : E_r_out1;
  assign b_mag = b_neg ? -E_r_out2 : E_r_out2;

  e_muldiv_core #(
    .DATA_WIDTH(W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == CALC),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= OP_MUL;
      rd_q        <= '0;
      res_neg_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      result_hold <= '0;
      rd_hold     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= CALC;
            count      <= '0;
            op_q       <= op_in;
            rd_q       <= E_rd;
            res_neg_q  <= is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
            div_zero_q <= is_div(op_in) && (E_r_out2 == '0);
          end
        end
        CALC: begin
          if (E_flush) begin
            state <= IDLE;
          end else begin
            count <= count + 5'd1;
            if (last_iter) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!E_flush) begin
            result_hold <= sel_result;
            rd_hold     <= rd_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    prod_s     = res_neg_q ? -product : product;
    quot_s     = res_neg_q ? -quotient : quotient;
    rem_s      = res_neg_q ? -remainder : remainder;
    sel_result = '0;
    case (op_q)
      OP_MUL:                       sel_result = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel_result = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:              sel_result = div_zero_q ? '1 : quot_s;
      OP_REM, OP_REMU:              sel_result = rem_s;
      default:                      sel_result = '0;
    endcase
  end

  // Result is live in DONE and held afterwards until the next completion.
  assign E_md_done   = (state == DONE) && !E_flush;
  assign E_md_stall  = accept || (state == CALC);
  assign E_md_result = (state == DONE) ? sel_result : result_hold;
  assign E_md_rd     = (state == DONE) ? rd_q : rd_hold;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed bench for e_muldiv_unit: arithmetic reference model, per-cycle
// done/result scoreboard, stall timing, flush and reset scenarios.
module tb_e_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic [4:0]   rd;
  logic         flush;
  logic         E_md_stall;
  logic         E_md_done;
  logic [W-1:0] E_md_result;
  logic [4:0]   E_md_rd;

  e_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .E_md_start  (start),
    .E_md_op     (op),
    .E_r_out1    (r1),
    .E_r_out2    (r2),
    .E_rd        (rd),
    .E_flush     (flush),
    .E_md_stall  (E_md_stall),
    .E_md_done   (E_md_done),
    .E_md_result (E_md_result),
    .E_md_rd     (E_md_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_rd_q[$];
  int           exp_cyc_q[$];
  bit           cmp_en = 0;
  logic [W-1:0] last_exp = '0;
  logic [4:0]   last_rd = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint       sa, sb, ua, ub;
    logic [63:0]  p;
    int           ia, ib;
    logic         ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Per-cycle compare: done must pulse exactly on the scheduled cycle.
  initial begin
    bit exp_done;
    forever begin
      @(negedge clk);
      #2;
      if (cmp_en) begin
        exp_done = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        check_bit("done", E_md_done, exp_done);
        if (exp_done) begin
          check("result", E_md_result, exp_q.pop_front());
          check("rd", 32'(E_md_rd), 32'(exp_rd_q.pop_front()));
          void'(exp_cyc_q.pop_front());
        end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
          checks++;
          failures++;
          $display("FAIL done_missed: got no pulse expected one at cycle %0d", exp_cyc_q[0]);
          void'(exp_q.pop_front());
          void'(exp_rd_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] e);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  // Called at a falling edge; the accept happens on the next rising edge.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] d, input bit push);
    start = 1'b1; flush = 1'b0; op = o; r1 = a; r2 = b; rd = d;
    if (push) begin
      exp_q.push_back(model(o, a, b));
      exp_rd_q.push_back(d);
      exp_cyc_q.push_back(cyc + 33);
    end
    #1 check_bit("stall_accept", E_md_stall, 1'b1);
  endtask

  // Operands wander during iteration; the unit must rely on its latched copy.
  task automatic calc_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      op = 3'($urandom_range(0, 7));
      r1 = $urandom;
      r2 = $urandom;
      rd = 5'($urandom_range(0, 31));
      #1 check_bit("stall_calc", E_md_stall, 1'b1);
    end
  endtask

  task automatic done_cycle();
    @(negedge clk);
    #1 check_bit("stall_done", E_md_stall, 1'b0);
  endtask

  task automatic release_idle();
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check_bit("stall_idle", E_md_stall, 1'b0);
    check("result_hold", E_md_result, last_exp);
    check("rd_hold", 32'(E_md_rd), 32'(last_rd));
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] d);
    check("model_pin", model(v.op, v.a, v.b), v.exp);
    start_op(v.op, v.a, v.b, d, 1'b1);
    calc_cycles(32);
    done_cycle();
    last_exp = v.exp;
    last_rd  = d;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; r1 = '0; r2 = '0; rd = '0;

    add(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB); // MUL 7 * -3
    add(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); // MULH
    add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); // MULHU
    add(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); // MULHSU
    add(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD); // DIV -7/2
    add(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF); // REM -7/2
    add(3'b101, 32'd100,       32'd7,         32'd14);        // DIVU
    add(3'b111, 32'd100,       32'd7,         32'd2);         // REMU
    add(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF); // DIV by zero
    add(3'b110, 32'd5,         32'd0,         32'd5);         // REM by zero
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); // DIV overflow
    add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         // REM overflow
    add(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3);         // DIV -7/-2
    add(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1);         // REM 7/-2
    add(3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF); // DIV -5/0
    add(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB); // REM -5/0
    add(3'b101, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF); // DIVU x/0
    add(3'b111, 32'd5,         32'd0,         32'd5);         // REMU 5/0
    add(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); // MULHSU min * umax
    add(3'b011, 32'h8000_0000, 32'd2,         32'd1);         // MULHU
    add(3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0);         // MUL low half wraps
    add(3'b001, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF); // MULH -1 * 1
    add(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);         // MUL -1 * -1
    add(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         // DIVU unsigned
    add(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); // REMU unsigned
    add(3'b001, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF); // MULH 7 * -3

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("reset_done", E_md_done, 1'b0);
    check_bit("reset_stall", E_md_stall, 1'b0);
    check("reset_result", E_md_result, 32'd0);
    check("reset_rd", 32'(E_md_rd), 32'd0);
    cmp_en = 1;

    foreach (vecs[i]) begin
      @(negedge clk);
      run_vec(vecs[i], 5'((i * 7 + 5) % 32));
      release_idle();
    end

    // Start held through DONE is ignored; a fresh accept lands at T+34.
    @(negedge clk);
    run_vec(vecs[4], 5'd11);
    @(negedge clk);
    run_vec(vecs[6], 5'd12);
    release_idle();

    // Flush in CALC at T+10, new accept at T+11 completes at T+44.
    @(negedge clk);
    start_op(3'b000, 32'd3, 32'd4, 5'd7, 1'b0);
    calc_cycles(9);
    @(negedge clk);
    flush = 1'b1;
    #1 check_bit("stall_flush_calc", E_md_stall, 1'b1);
    @(negedge clk);
    run_vec(vecs[7], 5'd9);
    release_idle();

    // Flush in DONE: no pulse, held result untouched.
    @(negedge clk);
    start_op(3'b011, 32'h8000_0000, 32'd2, 5'd3, 1'b0);
    calc_cycles(32);
    @(negedge clk);
    flush = 1'b1;
    #1 check_bit("done_flushed", E_md_done, 1'b0);
    release_idle();

    // Reset at T+20 abandons the operation.
    @(negedge clk);
    start_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd21, 1'b0);
    calc_cycles(19);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("midrst_done", E_md_done, 1'b0);
    check_bit("midrst_stall", E_md_stall, 1'b0);
    check("midrst_result", E_md_result, 32'd0);
    check("midrst_rd", 32'(E_md_rd), 32'd0);
    repeat (20) @(negedge clk);

    #3;
    check("queue_drained", 32'(exp_cyc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_muldiv_unit.md
# e_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the decode→execute pipeline register. It takes the execute-stage register operands when an M-extension instruction is in execute and stalls the pipeline while it iterates. It then returns a 32-bit result and destination register for the execute→memory register to capture. All eight RV32M operations complete with a fixed, data-independent latency.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- E_md_start  in  1  M-extension instruction present in execute this cycle.
- E_md_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- E_r_out1  in  DATA_WIDTH  rs1 value (dividend / multiplicand), already forwarded.
- E_r_out2  in  DATA_WIDTH  rs2 value (divisor / multiplier), already forwarded.
- E_rd  in  5  destination register of the instruction.
- E_flush  in  1  kill the instruction in execute (branch redirect).
- E_md_stall  out  1  hold fetch, decode and the decode→execute register.
- E_md_done  out  1  result valid this cycle.
- E_md_result  out  DATA_WIDTH  operation result.
- E_md_rd  out  5  destination register latched at accept.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, E_md_start=1, E_flush=0: the unit accepts the instruction.
  - Latch op and rd.
  - Latch operand magnitudes and the result-sign flag, per op signedness.
  - Counter cleared; go to CALC.
- IDLE, E_md_start=1, E_flush=1: no accept; stay in IDLE.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add on 64-bit accumulator.
  - Divide: restoring shift-subtract on 33-bit partial remainder.
  - After iteration 32 (counter=31), go to DONE.
- DONE:
  - Apply sign correction and select the result.
  - E_md_done=1 for exactly one cycle; return to IDLE.
  - E_md_start is ignored in DONE, because the same instruction is still asserting it.
- E_md_start is ignored in CALC.
- E_flush in CALC or DONE: go to IDLE next cycle.
  - E_md_done is forced to 0 in that cycle.
  - No result is produced.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend.
  - DIV overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Both cases still take the full latency.
- Arithmetic:
  - Magnitude of 0x80000000 is taken as an unsigned 32-bit value.
  - Products are formed in 64 bits and negated in 64 bits when the result sign is negative.

## Timing
- Accept in cycle T.
- CALC occupies T+1..T+32.
- DONE in T+33: E_md_done=1, E_md_result and E_md_rd valid.
- Total latency is 33 cycles after accept.
- E_md_stall = (IDLE && E_md_start && !E_flush) || CALC. It is combinational and therefore high in T..T+32.
- E_md_stall is low in DONE, so the pipeline advances with the result in T+33.
- Back-to-back M instructions: the next accept occurs at the earliest in T+34.
- Reset values:
  - State IDLE, counter 0.
  - E_md_done=0, E_md_stall=0, E_md_result=0, E_md_rd=0.
- Reset mid-CALC: the operation is abandoned and no done pulse is produced.
- E_md_result and E_md_rd hold their last value outside DONE. Consumers qualify them with E_md_done.

## Structure
- Shared package muldiv_pkg holds:
  - md_op_e enum, encoded as the funct3 values.
  - md_state_e enum {IDLE, CALC, DONE}.
  - MD_ITERATIONS = 32.
  - Helper functions is_div(op) and op_signed_a/op_signed_b(op).
- Natural sub-module: e_muldiv_core, the iteration datapath (accumulator, partial remainder, quotient shift register).
  - e_muldiv_unit keeps the FSM, counter, sign handling, flush logic and result selection.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → done at T+33, result 0xFFFFFFEB, E_md_rd echoes rd=5, stall high T..T+32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5. Overflow: DIV 0x80000000/−1 → 0x80000000, REM → 0.
- E_flush at T+10 → IDLE at T+11, no E_md_done; a new accept at T+11 completes normally at T+44.
- rst at T+20 → all outputs 0 next cycle, no done pulse. E_md_start held through DONE is not re-accepted; a new start at T+34 is accepted.
